// File: rtl/weight_mutator_pkg.sv
// rtl/weight_mutator_pkg.sv - shared constants, FSM encoding and LFSR step for the weight mutator
package weight_mutator_pkg;

  localparam logic [15:0] MUT_LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] MUT_LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    MUT_IDLE = 2'd0,
    MUT_RUN  = 2'd1,
    MUT_DONE = 2'd2
  } mut_state_t;

  // Flat weight layout: each neuron carries one weight per input plus a threshold.
  function automatic int nn_weight_count(input int inputs, input int hidden, input int outputs);
    return hidden * (inputs + 1) + outputs * (hidden + 1);
  endfunction

  // Galois right-shift step; a non-zero state never reaches zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] r);
    return (r >> 1) ^ (r[0] ? MUT_LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/weight_mutator_lfsr16.sv
// rtl/weight_mutator_lfsr16.sv - 16-bit Galois LFSR with seed load and zero-seed guard
module weight_mutator_lfsr16
  import weight_mutator_pkg::*;
#(
  parameter logic [15:0] RESET_SEED = MUT_LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        advance,
  output logic [15:0] value
);

  // Load wins over advance; an all-zero seed would lock the LFSR, so it is replaced.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= RESET_SEED;
    end else if (load) begin
      value <= (load_value == 16'h0000) ? RESET_SEED : load_value;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/weight_mutator.sv
// rtl/weight_mutator.sv - derives one child weight vector from a parent by LFSR-driven perturbation
module weight_mutator
  import weight_mutator_pkg::*;
#(
  parameter int          DATA_WIDTH   = 8,
  parameter int          INPUT_SIZE   = 4,
  parameter int          HIDDEN_SIZE  = 4,
  parameter int          OUTPUT_SIZE  = 2,
  parameter logic [15:0] RESET_SEED   = MUT_LFSR_DEFAULT_SEED,
  localparam int         WEIGHT_COUNT = nn_weight_count(INPUT_SIZE, HIDDEN_SIZE, OUTPUT_SIZE)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               seed_load,
  input  logic [15:0]                        seed,
  input  logic [7:0]                         mutation_rate,
  input  logic [DATA_WIDTH*WEIGHT_COUNT-1:0] parent_weights,
  output logic                               busy,
  output logic                               done,
  output logic [DATA_WIDTH*WEIGHT_COUNT-1:0] child_weights
);

  localparam int IDX_W = $clog2(WEIGHT_COUNT);
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(WEIGHT_COUNT - 1);

  mut_state_t            state;
  mut_state_t            state_next;
  idx_t                  index;
  logic [DATA_WIDTH-1:0] work [WEIGHT_COUNT];
  logic [15:0]           lfsr_value;

  logic                  lfsr_load;
  logic                  lfsr_advance;
  logic [DATA_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0] mutated_word;
  logic                  mutate;
  logic [4:0]            mag;
  logic [DATA_WIDTH:0]   wide_word;
  logic [DATA_WIDTH:0]   mag_ext;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   diff;
  logic                  unused_lfsr_bits;

  // Seed loads are honoured only in IDLE, so a pass started together with a seed uses the new seed.
  assign lfsr_load    = (state == MUT_IDLE) && seed_load;
  assign lfsr_advance = (state == MUT_RUN);

  weight_mutator_lfsr16 #(
    .RESET_SEED (RESET_SEED)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .load       (lfsr_load),
    .load_value (seed),
    .advance    (lfsr_advance),
    .value      (lfsr_value)
  );

  assign unused_lfsr_bits = ^lfsr_value[14:12];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MUT_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: one RUN cycle per weight word, then a single DONE cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      MUT_IDLE: if (start) state_next = MUT_RUN;
      MUT_RUN:  if (index == LAST_IDX) state_next = MUT_DONE;
      MUT_DONE: state_next = MUT_IDLE;
      default:  state_next = MUT_IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      MUT_RUN:  busy = 1'b1;
      MUT_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Saturating perturbation of the current word: low byte gates, bits 11:8 size, bit 15 direction.
  always_comb begin
    cur_word  = work[index];
    mutate    = (lfsr_value[7:0] < mutation_rate);
    mag       = {1'b0, lfsr_value[11:8]} + 5'd1;
    wide_word = {1'b0, cur_word};
    mag_ext   = (DATA_WIDTH + 1)'(mag);
    sum       = wide_word + mag_ext;
    diff      = wide_word - mag_ext;
    mutated_word = cur_word;
    if (mutate) begin
      if (lfsr_value[15]) begin
        mutated_word = (wide_word < mag_ext) ? '0 : diff[DATA_WIDTH-1:0];
      end else begin
        mutated_word = sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
      end
    end
  end

  // Work register, index counter and child commit. The commit happens on the edge into DONE,
  // merging the last word's result, so child_weights is already valid while done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      index         <= '0;
      child_weights <= '0;
      for (int i = 0; i < WEIGHT_COUNT; i++) begin
        work[i] <= '0;
      end
    end else begin
      unique case (state)
        MUT_IDLE: begin
          if (start) begin
            index <= '0;
            for (int i = 0; i < WEIGHT_COUNT; i++) begin
              work[i] <= parent_weights[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
        MUT_RUN: begin
          work[index] <= mutated_word;
          index       <= index + idx_t'(1);
          if (index == LAST_IDX) begin
            for (int i = 0; i < WEIGHT_COUNT; i++) begin
              child_weights[i*DATA_WIDTH +: DATA_WIDTH] <=
                (idx_t'(i) == index) ? mutated_word : work[i];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_mutator.sv
// tb/tb_weight_mutator.sv - scoreboard bench for weight_mutator
module tb_weight_mutator;

  localparam int DW = 8;
  localparam int WC = 30;
  localparam int PW = DW * WC;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          seed_load;
  logic [15:0]   seed;
  logic [7:0]    mutation_rate;
  logic [PW-1:0] parent_weights;
  logic          busy;
  logic          done;
  logic [PW-1:0] child_weights;

  int passed = 0;
  int total  = 0;

  logic [15:0]   model_lfsr;
  logic [PW-1:0] exp_q[$];

  weight_mutator dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .seed_load      (seed_load),
    .seed           (seed),
    .mutation_rate  (mutation_rate),
    .parent_weights (parent_weights),
    .busy           (busy),
    .done           (done),
    .child_weights  (child_weights)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the LFSR sequence word by word with integer saturation.
  task automatic model_pass(input logic [PW-1:0] parent, input logic [7:0] rate,
                            input logic [15:0] r_in, output logic [PW-1:0] child,
                            output logic [15:0] r_out);
    logic [15:0] r;
    int w;
    int m;
    r = r_in;
    child = '0;
    for (int i = 0; i < WC; i++) begin
      w = int'(parent[i*DW +: DW]);
      if (r[7:0] < rate) begin
        m = int'(r[11:8]) + 1;
        if (r[15]) w = (w > m) ? w - m : 0;
        else       w = (w + m > 255) ? 255 : w + m;
      end
      child[i*DW +: DW] = 8'(w);
      r = {1'b0, r[15:1]} ^ (r[0] ? 16'hB400 : 16'h0000);
    end
    r_out = r;
  endtask

  // Push the expected child and pulse start for one accepted edge.
  task automatic launch(input logic [PW-1:0] parent, input logic [7:0] rate,
                        input bit do_seed, input logic [15:0] seed_val);
    logic [PW-1:0] e;
    logic [15:0]   r;
    r = do_seed ? ((seed_val == 16'h0000) ? 16'hACE1 : seed_val) : model_lfsr;
    model_pass(parent, rate, r, e, model_lfsr);
    exp_q.push_back(e);
    parent_weights = parent;
    mutation_rate  = rate;
    seed           = seed_val;
    seed_load      = do_seed;
    start          = 1'b1;
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
  endtask

  // Counts ticks from the accepting edge until done, bounded.
  task automatic wait_done(output int ticks, output int busy_cnt);
    ticks    = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && ticks < 100) begin
      tick();
      ticks++;
      if (busy) busy_cnt++;
    end
  endtask

  function automatic logic [PW-1:0] pop_exp();
    if (exp_q.size() == 0) return '0;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (child_weights !== '0) $display("FAIL reset_child got %h want 0", child_weights); else passed++;
    reset = 1'b0;
    model_lfsr = 16'hACE1;
    tick();
  endtask

  task automatic test_rate_zero();
    logic [PW-1:0] p, e;
    int t, b;
    for (int i = 0; i < WC; i++) p[i*DW +: DW] = 8'(i);
    launch(p, 8'd0, 1'b1, 16'h1234);
    wait_done(t, b);
    e = pop_exp();
    total++; if (t !== 31) $display("FAIL rate0_latency got %0d want 31", t); else passed++;
    total++; if (child_weights !== e) $display("FAIL rate0_model got %h want %h", child_weights, e); else passed++;
    total++; if (child_weights !== p) $display("FAIL rate0_copy got %h want %h", child_weights, p); else passed++;
    tick();
    if (busy) b++;
    total++; if (b !== 31) $display("FAIL rate0_busy_cycles got %0d want 31", b); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rate0_done_pulse got %b want 0", done); else passed++;
    total++; if (child_weights !== p) $display("FAIL rate0_hold got %h want %h", child_weights, p); else passed++;
  endtask

  task automatic test_saturate_add();
    logic [PW-1:0] p, e;
    int t, b;
    p = '1;
    launch(p, 8'd255, 1'b1, 16'h0001);
    wait_done(t, b);
    e = pop_exp();
    total++; if (done !== 1'b1) $display("FAIL sat_done got %b want 1", done); else passed++;
    total++; if (child_weights !== e) $display("FAIL sat_model got %h want %h", child_weights, e); else passed++;
    total++; if (child_weights[7:0] !== 8'hFF) $display("FAIL sat_word0 got %h want ff", child_weights[7:0]); else passed++;
    total++; if (child_weights[15:8] !== 8'hFA) $display("FAIL sat_word1 got %h want fa", child_weights[15:8]); else passed++;
    tick();
  endtask

  task automatic test_clamp_sub();
    logic [PW-1:0] p, e;
    int t, b, wrapped;
    p = '0;
    launch(p, 8'd255, 1'b0, 16'h0000);
    wait_done(t, b);
    e = pop_exp();
    wrapped = 0;
    for (int i = 0; i < WC; i++) if (child_weights[i*DW +: DW] >= 8'hF0) wrapped++;
    total++; if (child_weights !== e) $display("FAIL clamp_model got %h want %h", child_weights, e); else passed++;
    total++; if (wrapped !== 0) $display("FAIL clamp_wrap got %0d words want 0", wrapped); else passed++;
    tick();
  endtask

  task automatic test_zero_seed();
    logic [PW-1:0] p, e, first;
    int t, b;
    for (int i = 0; i < WC; i++) p[i*DW +: DW] = 8'($urandom_range(0, 255));
    seed = 16'h0000; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    model_lfsr = 16'hACE1;
    launch(p, 8'd200, 1'b0, 16'h0000);
    wait_done(t, b);
    e = pop_exp();
    first = child_weights;
    total++; if (first !== e) $display("FAIL zseed_model got %h want %h", first, e); else passed++;
    tick();
    launch(p, 8'd200, 1'b1, 16'h0000);
    wait_done(t, b);
    e = pop_exp();
    total++; if (child_weights !== e) $display("FAIL zseed_model2 got %h want %h", child_weights, e); else passed++;
    total++; if (child_weights !== first) $display("FAIL zseed_repeat got %h want %h", child_weights, first); else passed++;
    tick();
  endtask

  task automatic test_ignore_while_busy();
    logic [PW-1:0] p, e, got;
    int t, dcount, dtick, b;
    for (int i = 0; i < WC; i++) p[i*DW +: DW] = 8'($urandom_range(0, 255));
    launch(p, 8'd128, 1'b0, 16'h0000);
    t = 1; dcount = 0; dtick = 0; got = '0;
    while (t < 60) begin
      if (t == 5) start = 1'b1;
      if (t == 10) begin seed = 16'hBEEF; seed_load = 1'b1; end
      tick();
      t++;
      start = 1'b0; seed_load = 1'b0;
      if (done) begin dcount++; dtick = t; got = child_weights; end
    end
    e = pop_exp();
    total++; if (dcount !== 1) $display("FAIL ignore_done_count got %0d want 1", dcount); else passed++;
    total++; if (dtick !== 31) $display("FAIL ignore_done_tick got %0d want 31", dtick); else passed++;
    total++; if (got !== e) $display("FAIL ignore_child got %h want %h", got, e); else passed++;
    launch(p, 8'd128, 1'b0, 16'h0000);
    wait_done(t, b);
    e = pop_exp();
    total++; if (child_weights !== e) $display("FAIL ignore_lfsr_seq got %h want %h", child_weights, e); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_pass();
    logic [PW-1:0] p, e;
    int t, b;
    for (int i = 0; i < WC; i++) p[i*DW +: DW] = 8'($urandom_range(0, 255));
    launch(p, 8'd255, 1'b0, 16'h0000);
    repeat (11) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    model_lfsr = 16'hACE1;
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL midrst_done got %b want 0", done); else passed++;
    total++; if (child_weights !== '0) $display("FAIL midrst_child got %h want 0", child_weights); else passed++;
    launch(p, 8'd64, 1'b0, 16'h0000);
    wait_done(t, b);
    e = pop_exp();
    total++; if (t !== 31) $display("FAIL midrst_latency got %0d want 31", t); else passed++;
    total++; if (child_weights !== e) $display("FAIL midrst_child2 got %h want %h", child_weights, e); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] p1, p2, e1, e2;
    int t, b, gap;
    for (int i = 0; i < WC; i++) begin
      p1[i*DW +: DW] = 8'($urandom_range(0, 255));
      p2[i*DW +: DW] = 8'($urandom_range(0, 255));
    end
    launch(p1, 8'd100, 1'b1, 16'h5A5A);
    wait_done(t, b);
    e1 = pop_exp();
    total++; if (child_weights !== e1) $display("FAIL b2b_child1 got %h want %h", child_weights, e1); else passed++;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL b2b_done_start got busy %b want 0", busy); else passed++;
    total++; if (child_weights !== e1) $display("FAIL b2b_hold got %h want %h", child_weights, e1); else passed++;
    launch(p2, 8'd100, 1'b0, 16'h0000);
    wait_done(t, b);
    gap = t + 1;
    e2 = pop_exp();
    total++; if (gap !== WC + 2) $display("FAIL b2b_gap got %0d want %0d", gap, WC + 2); else passed++;
    total++; if (child_weights !== e2) $display("FAIL b2b_child2 got %h want %h", child_weights, e2); else passed++;
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; seed_load = 1'b0; seed = '0;
    mutation_rate = '0; parent_weights = '0; model_lfsr = 16'hACE1;
    test_reset();
    test_rate_zero();
    test_saturate_add();
    test_clamp_sub();
    test_zero_seed();
    test_ignore_while_busy();
    test_reset_mid_pass();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
